// File: rtl/lfsr_gen.sv
// Configurable Fibonacci/Galois LFSR word generator with a valid/ready output
// and lock-up detection. It applies a variable number of shifts per word in one clock.
module lfsr_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int STEPS_MAX  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic [DATA_WIDTH-1:0]          seed,
  input  logic [DATA_WIDTH-1:0]          tap,
  input  logic                           mode,
  input  logic [$clog2(STEPS_MAX+1)-1:0] steps,
  input  logic                           en,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic                           lockup,
  output logic [CNT_WIDTH-1:0]           word_cnt
);

  localparam int SW = $clog2(STEPS_MAX + 1);

  typedef enum logic [1:0] {IDLE, RUN, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] s_q, s_d;
  logic [DATA_WIDTH-1:0] tap_q, tap_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  lockup_q, lockup_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [SW-1:0]         effSteps;
  logic [DATA_WIDTH-1:0] stepped;
  logic                  accept;
  logic                  genCycle;

  function automatic logic [DATA_WIDTH-1:0] fibStep(input logic [DATA_WIDTH-1:0] s,
                                                    input logic [DATA_WIDTH-1:0] t);
    logic fb;
    fb = ^(s & t);
    return {fb, s[DATA_WIDTH-1:1]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] galStep(input logic [DATA_WIDTH-1:0] s,
                                                    input logic [DATA_WIDTH-1:0] t);
    return (s >> 1) ^ (s[0] ? t : '0);
  endfunction

  // Clamp the requested shift count into 1..STEPS_MAX.
  always_comb begin
    effSteps = steps;
    if (steps == '0) begin
      effSteps = SW'(1);
    end else if (steps > SW'(STEPS_MAX)) begin
      effSteps = SW'(STEPS_MAX);
    end
  end

  always_comb begin
    stepped = s_q;
    for (int i = 0; i < STEPS_MAX; i++) begin
      if (i < int'(effSteps)) begin
        stepped = mode_q ? galStep(stepped, tap_q) : fibStep(stepped, tap_q);
      end
    end
  end

  assign accept   = valid_q & out_ready;
  assign genCycle = (state_q == RUN) & en & (~valid_q | out_ready);

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    tap_d    = tap_q;
    mode_d   = mode_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    lockup_d = lockup_q;
    cnt_d    = cnt_q;
    if (load) begin
      s_d     = seed;
      tap_d   = tap;
      mode_d  = mode;
      valid_d = 1'b0;
      cnt_d   = '0;
      if (seed != '0) begin
        state_d  = RUN;
        lockup_d = 1'b0;
      end else begin
        state_d  = LOCKED;
        lockup_d = 1'b1;
      end
    end else begin
      if (accept && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      // A word that steps into zero is still delivered before halting.
      if (genCycle) begin
        s_d     = stepped;
        dout_d  = stepped;
        valid_d = 1'b1;
        if (stepped == '0) begin
          lockup_d = 1'b1;
          state_d  = LOCKED;
        end
      end else if (accept) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      s_q      <= '0;
      tap_q    <= '0;
      mode_q   <= 1'b0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      tap_q    <= tap_d;
      mode_q   <= mode_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign dout      = dout_q;
  assign lockup    = lockup_q;
  assign word_cnt  = cnt_q;

endmodule
